// File: rtl/camera_pkg.sv
// ==== camera_pkg : capture FSM states and OV7670 VGA geometry (rev 1.0) ====
`default_nettype none

package camera_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LINE_WAIT  = 2'd1,
    CAPTURE    = 2'd2
  } cap_state_t;

  localparam int BYTES_PER_LINE  = 1280;
  localparam int LINES_PER_FRAME = 480;

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
// ==== edge_sync : 2-flop synchronizer with history flop and rise/fall events (rev 1.0) ====
`default_nettype none

module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

`default_nettype wire

// File: rtl/camera_capture.sv
// ==== camera_capture : OV7670 luma capture, 1-bit threshold and decimation to framebuffer (rev 1.0) ====
`default_nettype none

module camera_capture
  import camera_pkg::*;
#(
  parameter int         ADDR_WIDTH = 15,
  parameter int         H_OUT      = 160,
  parameter int         V_OUT      = 120,
  parameter int         DECIM      = 4,
  parameter logic [7:0] THRESHOLD  = 8'd128,
  parameter int         Y_ODD      = 0
) (
  input  logic                  clk_25,
  input  logic                  reset_n,
  input  logic                  pclk,
  input  logic                  h_ref,
  input  logic                  v_sync,
  input  logic [7:0]            data_in,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  pixel,
  output logic                  frame_done
);

  localparam int                    DEC_LOG   = $clog2(DECIM);
  localparam logic [9:0]            COL_MASK  = 10'(DECIM - 1);
  localparam logic [8:0]            LINE_MASK = 9'(DECIM - 1);
  localparam logic [9:0]            H_LIM     = 10'(H_OUT);
  localparam logic [8:0]            V_LIM     = 9'(V_OUT);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIM  = ADDR_WIDTH'(H_OUT * V_OUT);
  localparam logic [10:0]           BYTE_LAST = 11'(BYTES_PER_LINE - 1);

  logic pclk_level_unused, pclk_rise, pclk_fall_unused;
  logic href_level, href_rise, href_fall;
  logic vsync_level_unused, vsync_rise, vsync_fall;

  edge_sync u_sync_pclk (
    .clk(clk_25), .rst_n(reset_n), .d(pclk),
    .level(pclk_level_unused), .rise(pclk_rise), .fall(pclk_fall_unused)
  );

  edge_sync u_sync_href (
    .clk(clk_25), .rst_n(reset_n), .d(h_ref),
    .level(href_level), .rise(href_rise), .fall(href_fall)
  );

  edge_sync u_sync_vsync (
    .clk(clk_25), .rst_n(reset_n), .d(v_sync),
    .level(vsync_level_unused), .rise(vsync_rise), .fall(vsync_fall)
  );

  // Data is two flops deep so data_s2 lines up with the pclk rise event.
  logic [7:0] data_s1, data_s2;

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      data_s1 <= 8'd0;
      data_s2 <= 8'd0;
    end else begin
      data_s1 <= data_in;
      data_s2 <= data_s1;
    end
  end

  cap_state_t            state, state_next;
  logic [10:0]           byte_cnt;
  logic [8:0]            line_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [9:0]            col;
  logic                  frame_start, frame_end, line_start, line_end, byte_take;
  logic                  keep;

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    line_start  = 1'b0;
    line_end    = 1'b0;
    byte_take   = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (vsync_fall) begin
          frame_start = 1'b1;
          state_next  = LINE_WAIT;
        end
      end
      LINE_WAIT: begin
        if (vsync_rise) begin
          frame_end  = 1'b1;
          state_next = WAIT_FRAME;
        end else if (href_rise) begin
          line_start = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (vsync_rise) begin
          frame_end  = 1'b1;
          state_next = WAIT_FRAME;
        end else begin
          byte_take = pclk_rise & href_level;
          if (href_fall) begin
            line_end   = 1'b1;
            state_next = LINE_WAIT;
          end
        end
      end
      default: state_next = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) state <= WAIT_FRAME;
    else          state <= state_next;
  end

  assign col  = byte_cnt[10:1];
  // Fixed-length lines make the running address equal to row*H_OUT+col.
  assign keep = byte_take
             && (byte_cnt[0] == Y_ODD[0])
             && ((col & COL_MASK) == 10'd0)
             && ((line_cnt & LINE_MASK) == 9'd0)
             && ((col >> DEC_LOG) < H_LIM)
             && ((line_cnt >> DEC_LOG) < V_LIM)
             && (addr_cnt < ADDR_LIM);

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt   <= 11'd0;
      line_cnt   <= 9'd0;
      addr_cnt   <= '0;
      we         <= 1'b0;
      pixel      <= 1'b0;
      write_addr <= '0;
      frame_done <= 1'b0;
    end else begin
      we         <= keep;
      frame_done <= frame_end;
      if (frame_start) begin
        line_cnt <= 9'd0;
        addr_cnt <= '0;
      end
      if (line_start) byte_cnt <= 11'd0;
      if (byte_take && byte_cnt != BYTE_LAST) byte_cnt <= byte_cnt + 11'd1;
      if (line_end && line_cnt != 9'h1FF) line_cnt <= line_cnt + 9'd1;
      if (keep) begin
        addr_cnt   <= addr_cnt + 1'b1;
        write_addr <= addr_cnt;
        pixel      <= (data_s2 >= THRESHOLD);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_camera_capture.sv
// ==== tb_camera_capture : directed self-checking bench for camera_capture (rev 1.0) ====
`default_nettype none

module tb_camera_capture;

  localparam int HT = 8;
  localparam int VT = 6;

  logic        clk_25 = 1'b0;
  logic        reset_n = 1'b0;
  logic        pclk = 1'b0;
  logic        h_ref = 1'b0;
  logic        v_sync = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        we;
  logic [14:0] write_addr;
  logic        pixel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int q_addr[$];
  int q_pix[$];
  int fd_cnt = 0;

  camera_capture #(
    .ADDR_WIDTH(15), .H_OUT(HT), .V_OUT(VT), .DECIM(4),
    .THRESHOLD(8'd128), .Y_ODD(0)
  ) dut (
    .clk_25(clk_25), .reset_n(reset_n), .pclk(pclk), .h_ref(h_ref),
    .v_sync(v_sync), .data_in(data_in), .we(we), .write_addr(write_addr),
    .pixel(pixel), .frame_done(frame_done)
  );

  always #5 clk_25 = ~clk_25;

  always @(posedge clk_25) begin
    #1;
    if (we) begin
      q_addr.push_back(int'(write_addr));
      q_pix.push_back(int'(pixel));
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] luma(input int mode, input int col);
    case (mode)
      1:       luma = 8'(col * 8);
      2:       luma = 8'(col * 8 - 1);
      default: luma = 8'd200;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk_25); pclk = 1'b0; data_in = d;
    @(negedge clk_25);
    @(negedge clk_25); pclk = 1'b1;
    @(negedge clk_25);
  endtask

  task automatic vsync_pulse();
    @(negedge clk_25); v_sync = 1'b1;
    repeat (8) @(negedge clk_25);
    v_sync = 1'b0;
    repeat (8) @(negedge clk_25);
  endtask

  task automatic drive_frame(input int nlines, input int nbytes, input int mode, input int rst_line);
    for (int l = 0; l < nlines; l++) begin
      @(negedge clk_25); h_ref = 1'b1; pclk = 1'b0;
      repeat (3) @(negedge clk_25);
      for (int b = 0; b < nbytes; b++) begin
        if (l == rst_line && b == 20) begin
          @(negedge clk_25); reset_n = 1'b0;
          #1;
          check("async_rst_addr", write_addr, 0);
          check("async_rst_pixel", pixel, 0);
          check("async_rst_we", we, 0);
          q_addr.delete(); q_pix.delete(); fd_cnt = 0;
          repeat (2) @(negedge clk_25);
          reset_n = 1'b1;
        end
        send_byte(b[0] ? 8'd255 : luma(mode, b >> 1));
      end
      @(negedge clk_25); pclk = 1'b0;
      repeat (2) @(negedge clk_25);
      h_ref = 1'b0;
      repeat (4) @(negedge clk_25);
    end
  endtask

  task automatic check_frame(input string tag, input int mode, input int nexp, input int fd_exp);
    check($sformatf("%s_count", tag), q_addr.size(), nexp);
    check($sformatf("%s_fdone", tag), fd_cnt, fd_exp);
    for (int i = 0; i < q_addr.size() && i < nexp; i++) begin
      check($sformatf("%s_addr%0d", tag, i), q_addr[i], i);
      check($sformatf("%s_pix%0d", tag, i), q_pix[i],
            (luma(mode, (i % HT) * 4) >= 8'd128) ? 1 : 0);
    end
    q_addr.delete(); q_pix.delete(); fd_cnt = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk_25);
    check("rst_we", we, 0);
    check("rst_pixel", pixel, 0);
    check("rst_addr", write_addr, 0);
    check("rst_fdone", frame_done, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_25);
    vsync_pulse();

    // Single byte: first sampled high at edge N, write expected at N+2 only.
    @(negedge clk_25); h_ref = 1'b1; data_in = 8'd200;
    repeat (4) @(negedge clk_25);
    pclk = 1'b1;
    @(posedge clk_25); #1; check("lat_we_n0", we, 0);
    @(posedge clk_25); #1; check("lat_we_n1", we, 0);
    @(posedge clk_25); #1;
    check("lat_we_n2", we, 1);
    check("lat_addr_n2", write_addr, 0);
    check("lat_pix_n2", pixel, 1);
    @(posedge clk_25); #1; check("lat_we_n3", we, 0);
    @(negedge clk_25); pclk = 1'b0;
    repeat (2) @(negedge clk_25);
    h_ref = 1'b0;
    repeat (4) @(negedge clk_25);

    @(negedge clk_25); v_sync = 1'b1;
    @(posedge clk_25); #1; check("fd_n0", frame_done, 0);
    @(posedge clk_25); #1; check("fd_n1", frame_done, 0);
    @(posedge clk_25); #1; check("fd_n2", frame_done, 1);
    @(posedge clk_25); #1; check("fd_n3", frame_done, 0);
    repeat (6) @(negedge clk_25);
    v_sync = 1'b0;
    repeat (8) @(negedge clk_25);
    q_addr.delete(); q_pix.delete(); fd_cnt = 0;

    drive_frame(VT * 4, HT * 8, 0, -1); vsync_pulse();
    check_frame("full", 0, HT * VT, 1);

    drive_frame(VT * 4, HT * 8, 1, -1); vsync_pulse();
    check_frame("ramp", 1, HT * VT, 1);

    drive_frame(4, HT * 8, 0, -1); vsync_pulse();
    check_frame("short", 0, HT, 1);

    drive_frame(VT * 4, HT * 8, 2, -1); vsync_pulse();
    check_frame("ramp127", 2, HT * VT, 1);

    drive_frame(VT * 4, HT * 8, 0, 10); vsync_pulse();
    check("rst_mid_nowrites", q_addr.size(), 0);
    check("rst_mid_nofdone", fd_cnt, 0);
    q_addr.delete(); q_pix.delete(); fd_cnt = 0;

    drive_frame(VT * 4, HT * 8, 1, -1); vsync_pulse();
    check_frame("after_rst", 1, HT * VT, 1);

    drive_frame(VT * 4 + 6, HT * 8 + 8, 2, -1); vsync_pulse();
    check_frame("oversize", 2, HT * VT, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
